// File: rtl/dpc_pkg.sv
// Shared constants and helpers for the dead-pixel-correction neighbour packer.
package dpc_pkg;
  localparam int COUNT_W    = 4;
  localparam int CENTER_TAP = 4;
  localparam int NBR_TAP [0:7] = '{0, 1, 2, 3, 5, 6, 7, 8};

  // Bit k of each mask is tap k = 3*r+c of the 3x3 window.
  localparam logic [8:0] TOP_M   = 9'b000_000_111;
  localparam logic [8:0] BOT_M   = 9'b111_000_000;
  localparam logic [8:0] LEFT_M  = 9'b001_001_001;
  localparam logic [8:0] RIGHT_M = 9'b100_100_100;

  function automatic logic [8:0] border_mask(input logic top, input logic bot,
                                             input logic left, input logic right);
    return ({9{top}} & TOP_M) | ({9{bot}} & BOT_M) |
           ({9{left}} & LEFT_M) | ({9{right}} & RIGHT_M);
  endfunction
endpackage

// File: rtl/dpc_neighbor_packer_if.sv
// Window-in / packed-neighbours-out bundle of the neighbour packer.
// The stats outputs exist only when DPC_PACK_STATS_EN is defined.
interface dpc_neighbor_packer_if #(parameter int DATA_WIDTH = 16);
  logic                    in_valid;
  logic                    in_sof;
  logic                    in_eol;
  logic [9*DATA_WIDTH-1:0] in_win;
  logic [8:0]              in_bad;
  logic                    valid_out;
  logic [DATA_WIDTH-1:0]   data0, data1, data2, data3, data4, data5, data6, data7;
  logic [dpc_pkg::COUNT_W-1:0] valid_count;
  logic [DATA_WIDTH-1:0]   center_out;
  logic                    center_bad;
  logic                    line_err;
`ifdef DPC_PACK_STATS_EN
  logic [23:0]             stat_bad_center;
  logic [23:0]             stat_empty;
`endif

  modport master (
    output in_valid, in_sof, in_eol, in_win, in_bad,
    input  valid_out, data0, data1, data2, data3, data4, data5, data6, data7,
           valid_count, center_out, center_bad, line_err
`ifdef DPC_PACK_STATS_EN
    , input stat_bad_center, stat_empty
`endif
  );

  modport slave (
    input  in_valid, in_sof, in_eol, in_win, in_bad,
    output valid_out, data0, data1, data2, data3, data4, data5, data6, data7,
           valid_count, center_out, center_bad, line_err
`ifdef DPC_PACK_STATS_EN
    , output stat_bad_center, stat_empty
`endif
  );
endinterface

// File: rtl/dpc_compact8.sv
// Order-preserving compactor: kept entries move to the lowest slots, the rest read 0.
module dpc_compact8
  import dpc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [7:0][DATA_WIDTH-1:0] nbr,
  input  logic [7:0]                 keep,
  output logic [7:0][DATA_WIDTH-1:0] slot,
  output logic [COUNT_W-1:0]         count
);

  // The running count is the prefix sum, i.e. the destination slot of the next kept entry.
  always_comb begin
    slot  = '0;
    count = '0;
    for (int i = 0; i < 8; i++) begin
      slot[count[2:0]] = keep[i] ? nbr[i] : slot[count[2:0]];
      count            = count + {3'b000, keep[i]};
    end
  end

endmodule

// File: rtl/dpc_neighbor_packer.sv
// Two-stage neighbour packer: stage 1 tracks frame position and registers the keep mask,
// stage 2 compacts the kept neighbours. Optional per-frame stats: DPC_PACK_STATS_EN.
module dpc_neighbor_packer
  import dpc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 512
) (
  input logic                   clk,
  input logic                   rst_n,
  dpc_neighbor_packer_if.slave  bus
);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col_r, col_s, col_nxt_s;
  logic [ROW_W-1:0] row_r, row_s, row_nxt_s;
  logic             wrap_s, err_s, line_err_r;
  logic [8:0]       keep_s;

  logic                    s1_valid_r;
  logic [9*DATA_WIDTH-1:0] s1_win_r;
  logic [8:0]              s1_keep_r;

  logic [7:0][DATA_WIDTH-1:0] nbr_s, slot_s, data_r;
  logic [7:0]                 nbr_keep_s;
  logic [COUNT_W-1:0]         count_s, count_r;
  logic                       valid_out_r, center_bad_r;
  logic [DATA_WIDTH-1:0]      center_r;

  // An in_sof window is at (0,0) regardless of where the counters were.
  always_comb begin
    col_s     = bus.in_sof ? '0 : col_r;
    row_s     = bus.in_sof ? '0 : row_r;
    keep_s    = ~bus.in_bad & ~border_mask(row_s == '0, row_s == ROW_LAST,
                                           col_s == '0, col_s == COL_LAST);
    wrap_s    = bus.in_eol || (col_s == COL_LAST);
    err_s     = wrap_s && !bus.in_sof && !(bus.in_eol && (col_s == COL_LAST));
    col_nxt_s = wrap_s ? '0 : col_s + COL_W'(1);
    row_nxt_s = !wrap_s ? row_s : ((row_s == ROW_LAST) ? '0 : row_s + ROW_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r      <= '0;
      row_r      <= '0;
      line_err_r <= 1'b0;
    end else begin
      line_err_r <= bus.in_valid & err_s;
      if (bus.in_valid) begin
        col_r <= col_nxt_s;
        row_r <= row_nxt_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_win_r   <= '0;
      s1_keep_r  <= '0;
    end else begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_win_r  <= bus.in_win;
        s1_keep_r <= keep_s;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      nbr_s[i]      = s1_win_r[NBR_TAP[i]*DATA_WIDTH +: DATA_WIDTH];
      nbr_keep_s[i] = s1_keep_r[NBR_TAP[i]];
    end
  end

  dpc_compact8 #(.DATA_WIDTH(DATA_WIDTH)) u_compact (
    .nbr   (nbr_s),
    .keep  (nbr_keep_s),
    .slot  (slot_s),
    .count (count_s)
  );

  // The border never drops the centre tap, so its keep bit is just the inverted bad flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out_r  <= 1'b0;
      data_r       <= '0;
      count_r      <= '0;
      center_r     <= '0;
      center_bad_r <= 1'b0;
    end else begin
      valid_out_r <= s1_valid_r;
      if (s1_valid_r) begin
        data_r       <= slot_s;
        count_r      <= count_s;
        center_r     <= s1_win_r[CENTER_TAP*DATA_WIDTH +: DATA_WIDTH];
        center_bad_r <= ~s1_keep_r[CENTER_TAP];
      end
    end
  end

  assign bus.valid_out   = valid_out_r;
  assign bus.data0       = data_r[0];
  assign bus.data1       = data_r[1];
  assign bus.data2       = data_r[2];
  assign bus.data3       = data_r[3];
  assign bus.data4       = data_r[4];
  assign bus.data5       = data_r[5];
  assign bus.data6       = data_r[6];
  assign bus.data7       = data_r[7];
  assign bus.valid_count = count_r;
  assign bus.center_out  = center_r;
  assign bus.center_bad  = center_bad_r;
  assign bus.line_err    = line_err_r;

`ifdef DPC_PACK_STATS_EN
  logic        s1_sof_r;
  logic [23:0] bc_cnt_r, em_cnt_r, bc_lat_r, em_lat_r;

  function automatic logic [23:0] sat_inc(input logic [23:0] v, input logic en);
    return (en && (v != 24'hFF_FFFF)) ? v + 24'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sof_r <= 1'b0;
    end else if (bus.in_valid) begin
      s1_sof_r <= bus.in_sof;
    end else begin
      s1_sof_r <= s1_sof_r;
    end
  end

  // The in_sof window publishes the previous frame's totals and starts the new frame's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_cnt_r <= 24'd0;
      em_cnt_r <= 24'd0;
      bc_lat_r <= 24'd0;
      em_lat_r <= 24'd0;
    end else if (s1_valid_r) begin
      if (s1_sof_r) begin
        bc_lat_r <= bc_cnt_r;
        em_lat_r <= em_cnt_r;
        bc_cnt_r <= sat_inc(24'd0, ~s1_keep_r[CENTER_TAP]);
        em_cnt_r <= sat_inc(24'd0, count_s == '0);
      end else begin
        bc_cnt_r <= sat_inc(bc_cnt_r, ~s1_keep_r[CENTER_TAP]);
        em_cnt_r <= sat_inc(em_cnt_r, count_s == '0);
      end
    end
  end

  assign bus.stat_bad_center = bc_lat_r;
  assign bus.stat_empty      = em_lat_r;
`endif

endmodule
